serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller that time-shares a single 1-bit full-subtractor cell across WIDTH cycles. It computes diff = a - b - bin, LSB first, and chains the borrow through a register. It sits between a requester (start/done handshake) and the full-subtractor datapath. It trades latency for area in small arithmetic units.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse/level; sampled only when ready to accept
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result is valid
diff  output  WIDTH  result; held stable from done until next accepted start
bout  output  1  final borrow-out; held with diff

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Shift registers, borrow register and counter are cleared.
  - Reset overrides every other input, including mid-operation; any partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge, the block:
  - loads a_sr<=a, b_sr<=b, brw<=bin, cnt<=0;
  - goes to SHIFT with busy=1.
- SHIFT: each edge applies the full-subtractor to (a_sr[0], b_sr[0], brw), then:
  - shifts the difference bit into diff_sr MSB; diff_sr shifts right;
  - shifts a_sr and b_sr right;
  - sets brw<=borrow, cnt<=cnt+1.
- SHIFT exit: on the edge where cnt reaches WIDTH-1, state goes to DONE, with:
  - diff<=final diff_sr, bout<=final borrow;
  - busy=0, done=1.
- DONE lasts one cycle. Next edge:
  - start=1: operands are captured exactly as from IDLE, state goes to SHIFT (back-to-back).
  - start=0: state goes to IDLE. done returns to 0 in both cases.
- Latency: start accepted at edge E; done is high in the cycle following edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Busy behaviour:
  - start while in SHIFT is ignored; no queuing, no error.
  - Changes on a/b/bin after capture have no effect.
- WIDTH=1: a single SHIFT cycle, then DONE.
- Arithmetic: modulo 2^WIDTH. bout=1 exactly when a < b+bin (unsigned).
- diff/bout stay unchanged outside DONE transitions and are never driven from partial shift state.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated together with diff.
  - ovf=1 when the signed (two's-complement) result overflows, i.e. borrow into MSB XOR borrow out of MSB.
  - The block keeps the borrow into the MSB stage in a register.
- Undefined: the ovf port and its register do not exist. All other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant.
- One sub-module: the existing combinational full-subtractor cell fullsub (a, b, c -> differ, barrow), instantiated once.
- Counter and FSM stay inline.

Test Plan:
- WIDTH=8: a=200, b=55, bin=0, start pulse -> done one cycle at edge E+8+1, diff=145, bout=0; busy high for exactly 8 cycles.
- a=5, b=10, bin=0 -> diff=251, bout=1. Then a=0, b=0, bin=1 -> diff=255, bout=1.
- Start held high through SHIFT with changing a/b -> ignored; result equals the originally captured operands (a=100, b=1 -> diff=99).
- Back-to-back: start=1 in the DONE cycle with a=9, b=3 -> second done 9 cycles later with diff=6; first result visible for its DONE cycle.
- rst_n=0 at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0, bout=0, state IDLE. A new start then produces a correct result.
- With SERIAL_SUB_OVF_EN, signed 8-bit operands:
  - a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1;
  - a=8'h10, b=8'h01 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Requester <-> serial subtractor handshake and operand/result bus.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_sub_ctrl_fullsub.sv
// Combinational 1-bit full subtractor: differ = a - b - c, barrow set when a < b + c.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic differ,
  output logic barrow
);

  assign differ = a ^ b ^ c;
  assign barrow = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fullsub cell reused LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff_sr_nxt;

  fullsub u_fullsub (
    .a      (r_a_sr[0]),
    .b      (r_b_sr[0]),
    .c      (r_brw),
    .differ (w_d),
    .barrow (w_bo)
  );

  // Widened concatenation keeps the right shift legal when WIDTH == 1.
  assign w_shift       = {w_d, r_diff_sr};
  assign w_diff_sr_nxt = w_shift[WIDTH:1];
  assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept      = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_brw     <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_a_sr    <= r_a_sr >> 1;
          r_b_sr    <= r_b_sr >> 1;
          r_diff_sr <= w_diff_sr_nxt;
          r_brw     <= w_bo;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff  <= w_diff_sr_nxt;
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            // r_brw here is the borrow into the MSB stage.
            r_ovf   <= r_brw ^ w_bo;
`endif
            r_state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_brw   <= bus.bin;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus randomized operations vs. an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  bit         hold_chg = 1'b0;
  logic [W-1:0] exp_d;
  logic         exp_bo;
  logic         exp_ov;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    longint ua, ub, sa, sb, r;
    ua = longint'(a);
    ub = longint'(b);
    exp_d  = W'(ua - ub - longint'(bi));
    exp_bo = (ua < ub + longint'(bi));
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    r  = sa - sb - longint'(bi);
    exp_ov = (r < -(longint'(1) << (W-1))) || (r > (longint'(1) << (W-1)) - 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    bus.a = a; bus.b = b; bus.bin = bi; bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_chg) bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("done_after_accept", 64'(bus.done), 64'd0);
  endtask

  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int edges = 0;
    int bcnt  = 1;
    bit seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) bcnt++;
        if (hold_chg) begin bus.a = W'($urandom); bus.b = W'($urandom); end
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(edges), 64'(W));
    chk("busy_cycles", 64'(bcnt), 64'(W));
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    model(a, b, bi);
    chk("diff", 64'(bus.diff), 64'(exp_d));
    chk("bout", 64'(bus.bout), 64'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 64'(bus.ovf), 64'(exp_ov));
`endif
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_pulse_end", 64'(bus.done), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("diff_held", 64'(bus.diff), 64'(exp_d));
    chk("bout_held", 64'(bus.bout), 64'(exp_bo));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    issue(a, b, bi);
    finish_op(a, b, bi);
    idle_check();
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_bout", 64'(bus.bout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8'd200, 8'd55, 1'b0);
    run(8'd5, 8'd10, 1'b0);
    run(8'd0, 8'd0, 1'b1);

    // start held through SHIFT with wandering operands
    hold_chg = 1'b1;
    issue(8'd100, 8'd1, 1'b0);
    finish_op(8'd100, 8'd1, 1'b0);
    hold_chg = 1'b0;
    idle_check();

    // back-to-back: new start during the DONE cycle
    issue(8'd20, 8'd7, 1'b0);
    finish_op(8'd20, 8'd7, 1'b0);
    issue(8'd9, 8'd3, 1'b0);
    finish_op(8'd9, 8'd3, 1'b0);
    idle_check();

    // reset in the fourth SHIFT cycle discards the operation
    issue(8'd77, 8'd33, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("diff_stable_in_shift", 64'(bus.diff), 64'(exp_d));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_diff", 64'(bus.diff), 64'd0);
    chk("midrst_bout", 64'(bus.bout), 64'd0);
    @(posedge clk); #1;
    chk("midrst_idle", 64'(bus.busy), 64'd0);
    run(8'd150, 8'd151, 1'b1);

    run(8'h80, 8'h01, 1'b0);
    run(8'h10, 8'h01, 1'b0);
    run(8'h7F, 8'hFF, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      issue(ra, rb, rbi);
      finish_op(ra, rb, rbi);
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
